// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
//   Run/step/halt sequencer for the 5-stage MIPS pipeline. It generates the global
//   pipeline enable and a synchronous flush, accepts RUN/STEP/STOP/CLEAR debug commands,
//   drains the pipeline after IF reports a HALT (so HALT retires), and then parks in HALTED.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
//   cmd_ready depends only on the current state and never on cmd_valid. A command that
//   transfers but has no meaning in the current state is consumed and dropped.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (0 = reset)
//   cmd_valid     command present
//   cmd_op        00 RUN, 01 STEP, 10 STOP, 11 CLEAR
//   cmd_ready     command accepted on an edge with cmd_valid & cmd_ready
//   halt_fetched  IF holds HALT; only looked at in RUN and STEP
//   pipe_en       clock enable for PC and all pipeline registers
//   pipe_flush    synchronous clear of PC and pipeline registers
//   halted        sequencer is parked after a HALT
//   busy          sequencer is in RUN, STEP, DRAIN or FLUSH
//   cycle_count   enabled pipeline cycles since reset/CLEAR, saturating
//   state_dbg     current state encoding, for observation only
module pipeline_run_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             halt_fetched,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state_dbg
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4,
        ST_FLUSH  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             cmd_fire;
    logic             clear_count;

    // Outputs are pure decodes of the state register.
    assign pipe_en     = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign pipe_flush  = (state_q == ST_FLUSH);
    assign halted      = (state_q == ST_HALTED);
    assign busy        = pipe_en || pipe_flush;
    assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign cycle_count = cycle_count_q;
    assign state_dbg   = state_q;

    assign cmd_fire = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        flush_cnt_d = flush_cnt_q;
        clear_count = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN:   state_d = ST_RUN;
                        OP_STEP:  state_d = ST_STEP;
                        OP_CLEAR: begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FW'(FLUSH_CYCLES);
                            clear_count = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // A fetched HALT outranks any command arriving on the same edge.
                if (halt_fetched) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYCLES);
                end else if (cmd_fire && (cmd_op == OP_STOP)) begin
                    state_d = ST_IDLE;
                end else if (cmd_fire && (cmd_op == OP_CLEAR)) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYCLES);
                    clear_count = 1'b1;
                end
            end
            ST_STEP: begin
                if (halt_fetched) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The counter holds the number of drain cycles left including this one.
                if (drain_cnt_q <= DW'(1)) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            ST_HALTED: begin
                if (cmd_fire && (cmd_op == OP_CLEAR)) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FW'(FLUSH_CYCLES);
                    clear_count = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= FW'(1)) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = '0;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Clearing on FLUSH entry wins over the increment of a RUN cycle taking the CLEAR.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (clear_count) begin
            cycle_count_d = '0;
        end else if (pipe_en && (cycle_count_q != {CNT_W{1'b1}})) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: two instances (32-bit and 4-bit counters) share stimulus.
// A behavioural model tracks the sequencer as run/step/drain/flush/halt flags and counters.
module tb_pipeline_run_ctrl;
    localparam int D = 4;
    localparam int F = 2;
    localparam logic [1:0] OP_RUN = 2'b00, OP_STEP = 2'b01, OP_STOP = 2'b10, OP_CLEAR = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       halt_fetched = 1'b0;

    logic        a_ready, a_en, a_flush, a_halted, a_busy;
    logic [31:0] a_count;
    logic [2:0]  a_state;
    logic        b_ready, b_en, b_flush, b_halted, b_busy;
    logic [3:0]  b_count;
    logic [2:0]  b_state;

    pipeline_run_ctrl #(.DRAIN_CYCLES(D), .FLUSH_CYCLES(F), .CNT_W(32)) dut_a (
        .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(a_ready),
        .halt_fetched(halt_fetched), .pipe_en(a_en), .pipe_flush(a_flush), .halted(a_halted),
        .busy(a_busy), .cycle_count(a_count), .state_dbg(a_state)
    );

    pipeline_run_ctrl #(.DRAIN_CYCLES(D), .FLUSH_CYCLES(F), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(b_ready),
        .halt_fetched(halt_fetched), .pipe_en(b_en), .pipe_flush(b_flush), .halted(b_halted),
        .busy(b_busy), .cycle_count(b_count), .state_dbg(b_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit      m_running = 0, m_step = 0, m_halted = 0;
    int      m_drain = 0, m_flush = 0;
    longint  m_cnt = 0;
    int      m_cnt4 = 0;

    function automatic bit m_en();    return m_running || m_step || (m_drain > 0); endfunction
    function automatic bit m_fl();    return m_flush > 0; endfunction
    function automatic bit m_ready(); return !(m_step || (m_drain > 0) || (m_flush > 0)); endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running = 0; m_step = 0; m_halted = 0;
            m_drain = 0; m_flush = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            bit en, fire;
            en   = m_en();
            fire = cmd_valid && m_ready();
            if (en) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
            end
            if (m_drain > 0) begin
                m_drain = m_drain - 1;
                if (m_drain == 0) m_halted = 1;
            end else if (m_flush > 0) begin
                m_flush = m_flush - 1;
            end else if (m_step) begin
                m_step = 0;
                if (halt_fetched) m_drain = D;
            end else if (m_running) begin
                if (halt_fetched) begin
                    m_running = 0; m_drain = D;
                end else if (fire && cmd_op == OP_STOP) begin
                    m_running = 0;
                end else if (fire && cmd_op == OP_CLEAR) begin
                    m_running = 0; m_flush = F; m_cnt = 0; m_cnt4 = 0;
                end
            end else if (m_halted) begin
                if (fire && cmd_op == OP_CLEAR) begin
                    m_halted = 0; m_flush = F; m_cnt = 0; m_cnt4 = 0;
                end
            end else if (fire) begin
                if (cmd_op == OP_RUN) m_running = 1;
                else if (cmd_op == OP_STEP) m_step = 1;
                else if (cmd_op == OP_CLEAR) begin
                    m_flush = F; m_cnt = 0; m_cnt4 = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit busy_e;
        busy_e = m_en() || m_fl();
        check("a_pipe_en", a_en, m_en());
        check("a_pipe_flush", a_flush, m_fl());
        check("a_cmd_ready", a_ready, m_ready());
        check("a_halted", a_halted, m_halted);
        check("a_busy", a_busy, busy_e);
        check("a_cycle_count", a_count, m_cnt);
        check("b_pipe_en", b_en, m_en());
        check("b_halted", b_halted, m_halted);
        check("b_cycle_count", b_count, m_cnt4);
    end

    // ---------------- pulse monitors ----------------
    bit count_en = 0, count_fl = 0;
    int en_pulses = 0, fl_cycles = 0;
    always @(negedge clk) begin
        if (count_en && a_en) en_pulses++;
        if (count_fl && a_flush) fl_cycles++;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_cmd(input logic [1:0] op);
        int tries = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!a_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        check("cmd_accept_in_time", (tries < 50), 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halted();
        int n = 0;
        while (!a_halted && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", a_halted, 1'b1);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL global_timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset mid-operation
        send_cmd(OP_RUN);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t1_rst_pipe_en", a_en, 0);
        check("t1_rst_count", a_count, 0);
        check("t1_rst_ready", a_ready, 1);
        check("t1_rst_halted", a_halted, 0);
        check("t1_rst_flush", a_flush, 0);
        rst_n = 1'b1;
        halt_fetched = 1'b1;          // no effect in IDLE
        repeat (2) @(negedge clk);
        halt_fetched = 1'b0;
        check("t1_idle_pipe_en", a_en, 0);
        check("t1_idle_halted", a_halted, 0);
        check("t1_idle_count", a_count, 0);

        // 2: three STEPs
        count_en = 1;
        for (int i = 0; i < 3; i++) begin
            send_cmd(OP_STEP);
            check("t2_step_ready_low", a_ready, 0);
            check("t2_step_pipe_en", a_en, 1);
        end
        repeat (3) @(negedge clk);
        count_en = 0;
        check("t2_pulses", en_pulses, 3);
        check("t2_count", a_count, 3);

        // 3: RUN, HALT in 10th enabled cycle
        send_cmd(OP_CLEAR);
        repeat (2) @(negedge clk);
        send_cmd(OP_RUN);              // now in enabled cycle 1
        repeat (9) @(negedge clk);     // now in enabled cycle 10
        halt_fetched = 1'b1;
        @(negedge clk);
        halt_fetched = 1'b0;
        check("t3_drain_ready_low", a_ready, 0);
        wait_halted();
        check("t3_count", a_count, 14);
        send_cmd(OP_RUN);
        send_cmd(OP_STEP);
        repeat (2) @(negedge clk);
        check("t3_still_halted", a_halted, 1);
        check("t3_count_hold", a_count, 14);

        // 5: CLEAR from HALTED
        count_fl = 1;
        send_cmd(OP_CLEAR);
        check("t5_flush_c1", a_flush, 1);
        check("t5_count_cleared", a_count, 0);
        @(negedge clk);
        check("t5_flush_c2", a_flush, 1);
        @(negedge clk);
        check("t5_flush_done", a_flush, 0);
        check("t5_idle_ready", a_ready, 1);
        count_fl = 0;
        check("t5_flush_cycles", fl_cycles, 2);

        // 4: STOP and HALT on the same edge
        send_cmd(OP_RUN);
        repeat (3) @(negedge clk);
        check("t4_ready_before", a_ready, 1);
        cmd_valid = 1'b1; cmd_op = OP_STOP; halt_fetched = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; halt_fetched = 1'b0;
        check("t4_drain_en", a_en, 1);
        check("t4_drain_ready", a_ready, 0);
        wait_halted();
        check("t4_count", a_count, 8);

        // 6: saturation of the 4-bit counter
        send_cmd(OP_CLEAR);
        repeat (2) @(negedge clk);
        send_cmd(OP_RUN);
        repeat (20) @(negedge clk);
        check("t6_b_sat", b_count, 15);
        check("t6_a_count", a_count, 20);
        send_cmd(OP_STOP);
        check("t6_idle_en", b_en, 0);
        check("t6_b_sat_stop", b_count, 15);
        check("t6_a_count_stop", a_count, 21);
        @(negedge clk);
        check("t6_b_hold", b_count, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
